// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - falling-block game controller: spawn, gravity, move pulses, line/level scoring
// Optional level/speed-up logic is built only when GAME_CTRL_LEVEL_EN is defined.
module game_ctrl #(
  parameter int          BOARD_W   = 10,
  parameter logic [23:0] GRAV_DIV  = 24'd12_500_000,
  parameter logic [23:0] GRAV_STEP = 24'd750_000,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_btn_left,
  input  logic       i_btn_right,
  input  logic       i_btn_rot,
  input  logic       i_btn_down,
  input  logic       i_lock,
  input  logic       i_line_full,
  input  logic [2:0] i_line_cnt,
  input  logic       i_gameover,
  output logic       o_new_piece,
  output logic [2:0] o_shape,
  output logic [1:0] o_rotate,
  output logic [4:0] o_x,
  output logic [4:0] o_y,
  output logic       o_play_en,
  output logic       o_move_left,
  output logic       o_move_right,
  output logic       o_move_rotate,
  output logic       o_move_drop,
  output logic [2:0] o_next_shape,
  output logic [7:0] o_lines,
  output logic [3:0] o_level,
  output logic [1:0] o_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SPAWN = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam logic [4:0] SPAWN_X = 5'(BOARD_W / 2 - 1);

  // Shape 7 does not exist; fold it onto shape 0.
  function automatic logic [2:0] shape_of(input logic [15:0] v);
    shape_of = (v[2:0] == 3'd7) ? 3'd0 : v[2:0];
  endfunction

  logic [1:0]  state_q, state_d;
  logic [15:0] lfsr_q;
  logic        lfsr_fb;
  logic [2:0]  next_shape_q;
  logic [2:0]  shape_q;
  logic [4:0]  x_q;
  logic [23:0] grav_cnt_q;
  logic [23:0] period;
  logic        in_play;
  logic        grav_wrap;
  logic        grav_clr;
  logic        left_q, right_q, rot_q, drop_q;
  logic [7:0]  lines_q;
  logic [8:0]  lines_sum;

  assign in_play   = (state_q == S_PLAY);
  assign grav_wrap = (grav_cnt_q == period - 24'd1);
  // Counter restarts on spawn, on a natural wrap, and on a soft drop.
  assign grav_clr  = (state_q == S_SPAWN) || (in_play && (grav_wrap || i_btn_down));
  assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lines_sum = {1'b0, lines_q} + {6'd0, i_line_cnt};

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; gameover wins over lock
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_SPAWN;
      S_SPAWN: state_d = S_PLAY;
      S_PLAY: begin
        if (i_gameover)  state_d = S_OVER;
        else if (i_lock) state_d = S_SPAWN;
      end
      default: state_d = S_OVER;
    endcase
  end

  // Output logic; move pulses are suppressed outside PLAY and during a lock cycle
  always_comb begin
    o_state       = state_q;
    o_new_piece   = (state_q == S_SPAWN);
    o_shape       = (state_q == S_SPAWN) ? next_shape_q : shape_q;
    o_x           = (state_q == S_SPAWN) ? SPAWN_X : x_q;
    o_y           = 5'd0;
    o_rotate      = 2'd0;
    o_play_en     = in_play;
    o_move_left   = left_q  && in_play && !i_lock;
    o_move_right  = right_q && in_play && !i_lock;
    o_move_rotate = rot_q   && in_play && !i_lock;
    o_move_drop   = drop_q  && in_play && !i_lock;
    o_next_shape  = next_shape_q;
    o_lines       = lines_q;
  end

  // Free-running LFSR and preview shape, reloaded when a piece spawns
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lfsr_q       <= SEED;
      next_shape_q <= shape_of(SEED);
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
      if (state_q == S_SPAWN) next_shape_q <= shape_of(lfsr_q);
    end
  end

  // Latch the spawned piece so shape and position hold after SPAWN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shape_q <= 3'd0;
      x_q     <= 5'd0;
    end else if (state_q == S_SPAWN) begin
      shape_q <= next_shape_q;
      x_q     <= SPAWN_X;
    end
  end

  // Gravity counter runs only in PLAY
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                grav_cnt_q <= 24'd0;
    else if (grav_clr || !in_play) grav_cnt_q <= 24'd0;
    else                      grav_cnt_q <= grav_cnt_q + 24'd1;
  end

  // One-cycle-late move pulses; gravity and soft drop merge into a single drop
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
      rot_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      left_q  <= in_play && i_btn_left;
      right_q <= in_play && i_btn_right && !i_btn_left;
      rot_q   <= in_play && i_btn_rot;
      drop_q  <= in_play && (grav_wrap || i_btn_down);
    end
  end

  // Cumulative cleared lines, saturating
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)            lines_q <= 8'd0;
    else if (i_line_full) lines_q <= lines_sum[8] ? 8'hFF : lines_sum[7:0];
  end

`ifdef GAME_CTRL_LEVEL_EN
  logic [3:0]  level_q;
  logic [3:0]  residue_q;
  logic [4:0]  res_sum;
  logic [23:0] period_q;
  logic [23:0] period_calc;

  assign res_sum     = {1'b0, residue_q} + {2'b0, i_line_cnt};
  assign period_calc = GRAV_DIV - GRAV_STEP * {20'd0, level_q};
  assign period      = period_q;
  assign o_level     = level_q;

  // Every ten lines bump the level, saturating at 15
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      level_q   <= 4'd0;
      residue_q <= 4'd0;
    end else if (i_line_full) begin
      if (res_sum >= 5'd10) begin
        residue_q <= 4'(res_sum - 5'd10);
        if (level_q != 4'hF) level_q <= level_q + 4'd1;
      end else begin
        residue_q <= res_sum[3:0];
      end
    end
  end

  // Gravity period is resampled whenever the counter restarts
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         period_q <= GRAV_DIV;
    else if (grav_clr) period_q <= period_calc;
  end
`else
  assign period  = GRAV_DIV;
  assign o_level = 4'd0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - directed self-checking bench for game_ctrl (GRAV_DIV=8, GRAV_STEP=1)
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_rot = 1'b0, btn_down = 1'b0;
  logic       lock = 1'b0, line_full = 1'b0, gameover = 1'b0;
  logic [2:0] line_cnt = 3'd0;
  logic       new_piece, play_en, mv_left, mv_right, mv_rot, mv_drop;
  logic [2:0] shape, next_shape;
  logic [1:0] rotate, state;
  logic [4:0] x, y;
  logic [7:0] lines;
  logic [3:0] level;

  int total = 0;
  int bad = 0;

  logic [15:0] m_lfsr;
  logic [2:0]  m_next;
  logic [31:0] mask;
  int          n;

`ifdef GAME_CTRL_LEVEL_EN
  localparam int EXP_LVL1 = 1;
  localparam int EXP_LVLMAX = 15;
  localparam int EXP_PER = 7;
`else
  localparam int EXP_LVL1 = 0;
  localparam int EXP_LVLMAX = 0;
  localparam int EXP_PER = 8;
`endif

  game_ctrl #(.BOARD_W(10), .GRAV_DIV(24'd8), .GRAV_STEP(24'd1), .SEED(16'hACE1)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_btn_left(btn_left), .i_btn_right(btn_right), .i_btn_rot(btn_rot), .i_btn_down(btn_down),
    .i_lock(lock), .i_line_full(line_full), .i_line_cnt(line_cnt), .i_gameover(gameover),
    .o_new_piece(new_piece), .o_shape(shape), .o_rotate(rotate), .o_x(x), .o_y(y),
    .o_play_en(play_en), .o_move_left(mv_left), .o_move_right(mv_right),
    .o_move_rotate(mv_rot), .o_move_drop(mv_drop), .o_next_shape(next_shape),
    .o_lines(lines), .o_level(level), .o_state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] derive(input logic [15:0] v);
    derive = (v[2:0] == 3'd7) ? 3'd0 : v[2:0];
  endfunction

  // Reference LFSR, taps 16,14,13,11, stepping every clock like the hardware
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_drop(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!mv_drop && cycles < 20);
  endtask

  initial begin
    m_next = derive(16'hACE1);
    tick(); tick();
    check("rst_state", state, 0);
    check("rst_new_piece", new_piece, 0);
    check("rst_play_en", play_en, 0);
    check("rst_x", x, 0);
    check("rst_shape", shape, 0);
    check("rst_lines", lines, 0);
    check("rst_level", level, 0);
    check("rst_next_shape", next_shape, 1);
    rst = 1'b0;
    tick();
    check("idle_state", state, 0);

    // start pulse -> SPAWN
    start = 1'b1;
    tick();
    start = 1'b0;
    check("spawn_state", state, 1);
    check("spawn_new_piece", new_piece, 1);
    check("spawn_x", x, 4);
    check("spawn_y", y, 0);
    check("spawn_rotate", rotate, 0);
    check("spawn_shape", shape, m_next);
    m_next = derive(m_lfsr);
    tick();
    check("play_state", state, 2);
    check("play_en", play_en, 1);
    check("play_new_piece", new_piece, 0);
    check("play_x_hold", x, 4);
    check("play_next_shape", next_shape, m_next);

    // idle play: drops at cycles 8, 16, 24
    mask = 32'd0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (mv_drop) mask[i] = 1'b1;
    end
    check("gravity_mask", mask, 32'h0101_0100);

    // left+right together (counter now 0)
    btn_left = 1'b1; btn_right = 1'b1;
    tick();
    btn_left = 1'b0; btn_right = 1'b0;
    check("lr_left", mv_left, 1);
    check("lr_right", mv_right, 0);
    tick();
    check("left_one_cycle", mv_left, 0);
    tick(); tick(); tick();
    // counter is 5 here
    btn_down = 1'b1;
    tick();
    btn_down = 1'b0;
    check("soft_drop", mv_drop, 1);
    mask = 32'd0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (mv_drop) mask[i] = 1'b1;
    end
    check("after_soft_drop_mask", mask, 32'h0000_0100);

    btn_rot = 1'b1;
    tick();
    btn_rot = 1'b0;
    check("rotate_pulse", mv_rot, 1);
    btn_left = 1'b1;
    tick();
    btn_left = 1'b0;
    lock = 1'b1;
    #1;
    check("lock_gates_move", mv_left, 0);
    tick();
    lock = 1'b0;
    check("lock_spawn_state", state, 1);
    check("lock_spawn_strobe", new_piece, 1);
    check("lock_spawn_shape", shape, m_next);
    m_next = derive(m_lfsr);
    tick();
    check("lock_play_state", state, 2);

    // three clears of 4 lines
    line_cnt = 3'd4;
    line_full = 1'b1;
    tick(); tick(); tick();
    line_full = 1'b0;
    check("lines_12", lines, 12);
    check("level_after_12", level, EXP_LVL1);
    wait_drop(n);
    wait_drop(n);
    wait_drop(n);
    check("period_after_level", n, EXP_PER);

    // lock and gameover together -> OVER
    lock = 1'b1; gameover = 1'b1;
    tick();
    lock = 1'b0; gameover = 1'b0;
    check("over_state", state, 3);
    check("over_play_en", play_en, 0);
    check("over_new_piece", new_piece, 0);
    start = 1'b1; btn_left = 1'b1;
    tick();
    start = 1'b0; btn_left = 1'b0;
    check("over_ignores_start", state, 3);
    check("over_no_left", mv_left, 0);
    mask = 32'd0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (mv_drop) mask[i] = 1'b1;
    end
    check("over_no_drop", mask, 0);

    // saturation of lines and level
    line_cnt = 3'd4;
    line_full = 1'b1;
    for (int i = 0; i < 70; i++) tick();
    line_full = 1'b0;
    check("lines_sat", lines, 255);
    check("level_sat", level, EXP_LVLMAX);

    // reset, replay, then reset mid-PLAY
    rst = 1'b1;
    m_next = derive(16'hACE1);
    tick();
    rst = 1'b0;
    tick();
    check("rst2_state", state, 0);
    check("rst2_lines", lines, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("spawn2_shape", shape, m_next);
    m_next = derive(m_lfsr);
    tick();
    line_cnt = 3'd3; line_full = 1'b1; btn_left = 1'b1;
    tick();
    line_full = 1'b0; btn_left = 1'b0;
    check("play2_lines", lines, 3);
    check("play2_left", mv_left, 1);
    rst = 1'b1;
    #1;
    check("async_state", state, 0);
    check("async_left", mv_left, 0);
    check("async_play_en", play_en, 0);
    check("async_lines", lines, 0);
    check("async_x", x, 0);
    check("async_shape", shape, 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_left", mv_left, 0);
    check("post_rst_drop", mv_drop, 0);
    check("post_rst_state", state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
